// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO drain path.
package fifo_pkg;

  // Default data width of the FIFO and everything downstream of it
  localparam int unsigned DEF_FIFO_WIDTH = 16;

  // Width of the accepted-beat counter
  localparam int unsigned BEAT_CNT_W = 16;

  typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry in-order skid buffer: push at the tail, pop from the head.
// slot0 is always the head; slot1 holds the second entry when occ == 2.
module stream_skid2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;

  // Storage and occupancy update; simultaneous push/pop keeps occ and order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          // pop implies occ >= 1: with one entry the new word becomes the head,
          // with two the second entry advances and the new word takes its slot
          if (occ == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = slot0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain stage for the synchronous FIFO: issues reads against the empty flag,
// absorbs the one-cycle read latency in a 2-entry skid buffer and presents
// a framed valid/ready stream with an accepted-beat counter.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  localparam logic [7:0] LAST_POS = 8'(PKT_LEN - 1);

  logic [1:0]            occ;
  logic                  inflight;
  logic [7:0]            pos;
  logic                  pop;
  logic [2:0]            level;
  logic [FIFO_WIDTH-1:0] head_data;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // Entries the buffer will hold once the in-flight word lands and this
  // cycle's pop completes; a new read is allowed only if one slot stays free.
  assign level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = en && !fifo_empty && (level <= 3'd1);

  assign m_data = head_data;
  assign m_last = m_valid && (pos == LAST_POS);

  // Track the read issued last cycle whose data is on fifo_data now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  // Packet position and accepted-beat counter advance on every pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos      <= '0;
      beat_cnt <= '0;
    end else if (pop) begin
      pos      <= (pos == LAST_POS) ? '0 : pos + 8'd1;
      beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
    end
  end

  stream_skid2 #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain stage placed directly downstream of the synchronous FIFO. It issues `rd_en` against the FIFO's `empty` flag and absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer. It presents the data as a valid/ready stream with packet framing (`m_last`). It never causes FIFO underflow and sustains one beat per cycle when the sink is always ready.

## Interface
Parameters:
- `FIFO_WIDTH`, 16: data width; must match the FIFO.
- `PKT_LEN`, 4: beats per packet; `m_last` marks every PKT_LEN-th beat; range 1..255.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset. Shared with the FIFO.
- `en` in 1: when low, no new FIFO reads are issued. In-flight and buffered data still drain.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_data` in FIFO_WIDTH: FIFO `data_out`. Valid in the cycle after a read is sampled.
- `fifo_rd_en` out 1: FIFO read enable. Combinational.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: sink accepts the beat.
- `m_data` out FIFO_WIDTH: output beat data.
- `m_last` out 1: final beat of a packet.
- `beat_cnt` out 16: total beats accepted by the sink. Wraps at 2^16.

## Operation
- State:
  - `occ` (0..2): entries held in the skid buffer.
  - `inflight` (0/1): a read was issued last cycle and its data is on `fifo_data` this cycle.
  - `pos` (0..PKT_LEN-1): position within the current packet.
  - `beat_cnt`.
- pop = `m_valid && m_ready`.
- `fifo_rd_en` = `en && !fifo_empty && (occ + inflight - pop) <= 1`. Consequences:
  - A read is never issued while the FIFO is empty.
  - The buffer never exceeds 2 entries.
- `inflight` next = `fifo_rd_en`.
- While `inflight` = 1, `fifo_data` is written into the buffer tail at the clock edge.
- Buffer order is strict FIFO. The head drives `m_data`.
- `m_valid` = (`occ` != 0). There is no combinational path from `fifo_data` to `m_data`.
- Push and pop in the same cycle: `occ` is unchanged and the order is preserved.
- `m_data`/`m_valid` must stay stable while `m_valid && !m_ready`.
- `m_last` = `m_valid && (pos == PKT_LEN-1)`.
- On pop:
  - `pos` advances and wraps to 0 after PKT_LEN-1.
  - `beat_cnt` increments by 1 (modulo 2^16).
- PKT_LEN = 1: `m_last` equals `m_valid`.
- `en` low mid-packet: `pos` is held, and framing resumes where it stopped.
- Back-to-back reads with FIFO count 1: `fifo_empty` rises the next cycle, which blocks a second read. No underflow.
- Reset, any cycle:
  - `occ`, `inflight`, `pos`, `beat_cnt` clear to 0.
  - Buffered and in-flight data are discarded.
  - Outputs at reset: `fifo_rd_en` 0, `m_valid` 0, `m_last` 0, `m_data` 0, `beat_cnt` 0.

## Timing
- Read issued in cycle c (sampled at edge E1). `fifo_data` is valid in c+1 and captured at edge E2. `m_valid` is high in c+2.
- Latency from FIFO non-empty (with buffer empty, sink ready) to `m_valid`: 2 cycles.
- Steady state with `m_ready`=1 and a non-empty FIFO: one read and one pop per cycle, 100% throughput.
- Sink stall:
  - At most one further read is issued after `m_ready` drops, and `occ` saturates at 2.
  - Reads resume in the same cycle that pop asserts.
- `fifo_rd_en` depends combinationally on `m_ready`, `en`, `fifo_empty` and registered state only.

## Structure
- Package `fifo_pkg` holds:
  - The `FIFO_WIDTH` default constant.
  - typedef `fifo_word_t` (logic [FIFO_WIDTH-1:0]).
  - The beat counter width constant (16).
- Sub-module `stream_skid2`: 2-entry buffer with push/pop/occ and head data.
- The top level holds the read-issue logic, `inflight`, framing and counter.

## Test plan
- Reset, then write 0x0001..0x0004 into the FIFO with `m_ready`=1, `en`=1:
  - Beats appear 2 cycles after the first read, on consecutive cycles, in order.
  - `m_last` is set on 0x0004.
  - `beat_cnt`=4.
  - The FIFO never asserts `underflow`.
- Full FIFO (8 words), `m_ready` held 0 for 10 cycles, then 1:
  - Exactly 2 reads are issued during the stall and `occ`=2.
  - Then 8 beats stream in order at 1/cycle with no loss or duplication.
- `m_ready` toggles every cycle over 16 words:
  - Data order is preserved.
  - `m_data` is stable while stalled.
  - `fifo_rd_en` is never high when `fifo_empty`=1.
- `en` dropped after 2 beats of a PKT_LEN=4 packet, restored 5 cycles later:
  - No reads while low; the in-flight word is still delivered.
  - `m_last` lands on the 4th beat overall.
- `rst_n` asserted while `occ`=2 and `inflight`=1:
  - `m_valid`, `fifo_rd_en`, `beat_cnt` go to 0 immediately.
  - After release, new FIFO data streams normally with `pos`=0.
- PKT_LEN=1 and 65537 beats: `m_last` is high on every beat and `beat_cnt` wraps to 1.
